// File: rtl/net_axis_pkg.sv
// Shared definitions for the RX packet isolation buffer.
//   wr_state_e        : write-side FSM state (idle / writing a packet / dropping a packet)
//   DefaultDataWidth  : default stream data width in bits
//   DefaultAddrWidth  : default buffer address width (depth = 2**width beats)
//   StatsCntWidth     : width of the optional statistics counters
package net_axis_pkg;

    localparam int unsigned DefaultDataWidth = 64;
    localparam int unsigned DefaultAddrWidth = 9;
    localparam int unsigned StatsCntWidth    = 32;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWrite = 2'd1,
        StDrop  = 2'd2
    } wr_state_e;

endpackage

// File: rtl/isolation_sdp_ram.sv
// Simple dual-port RAM with a registered read port.
//   clk_i        : clock
//   we_i         : write enable
//   waddr_i      : write address
//   wdata_i      : write data
//   re_i         : read enable; rdata_o updates on the next edge and holds otherwise
//   raddr_i      : read address
//   rdata_o      : registered read data
module isolation_sdp_ram #(
    parameter int unsigned WIDTH      = 73,
    parameter int unsigned ADDR_WIDTH = 9
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [WIDTH-1:0]      wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [WIDTH-1:0]      rdata_o
);

    localparam int unsigned Depth = 1 << ADDR_WIDTH;

    logic [WIDTH-1:0] mem_q [Depth];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (re_i) begin
            rdata_o <= mem_q[raddr_i];
        end
    end

endmodule

// File: rtl/rx_packet_isolation.sv
// Store-and-forward RX packet buffer between the MAC RX stream and the user side.
// Beats are accepted without backpressure; a packet becomes visible to the reader only once
// its last beat arrives flagged good. Bad-FCS and overflowing packets are discarded whole.
//   clk156, reset          : clock, asynchronous active-high reset
//   s_axis_*               : MAC RX stream (no tready; tuser on last beat = good frame)
//   m_axis_*               : downstream stream with tready backpressure
//   rx_fifo_overflow       : 1-cycle pulse when a packet is dropped for lack of space
//   rx_bad_frame           : 1-cycle pulse when a packet is dropped for tuser=0
//   rx_good/bad/ovf_count  : saturating statistics, only when RX_PKT_ISOLATION_STATS_EN is
//                            defined; tied to 0 otherwise
module rx_packet_isolation
    import net_axis_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefaultDataWidth,
    parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned ADDR_WIDTH = DefaultAddrWidth
) (
    input  logic                     clk156,
    input  logic                     reset,
    input  logic [DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]    s_axis_tkeep,
    input  logic                     s_axis_tvalid,
    input  logic                     s_axis_tlast,
    input  logic                     s_axis_tuser,
    output logic [DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]    m_axis_tkeep,
    output logic                     m_axis_tvalid,
    output logic                     m_axis_tlast,
    input  logic                     m_axis_tready,
    output logic                     rx_fifo_overflow,
    output logic                     rx_bad_frame,
    output logic [StatsCntWidth-1:0] rx_good_count,
    output logic [StatsCntWidth-1:0] rx_bad_count,
    output logic [StatsCntWidth-1:0] rx_ovf_count
);

    localparam int unsigned PtrW   = ADDR_WIDTH + 1;
    localparam int unsigned EntryW = DATA_WIDTH + KEEP_WIDTH + 1;
    localparam int unsigned Depth  = 1 << ADDR_WIDTH;

    wr_state_e state_q, state_d;

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] commit_ptr_q, commit_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] used;
    logic            has_space;

    logic            ram_we;
    logic            bad_d, bad_q;
    logic            ovf_d, ovf_q;

    // Occupancy counts committed-but-unread entries plus the packet in progress.
    assign used      = wr_ptr_q - rd_ptr_q;
    assign has_space = used < PtrW'(Depth);

    // ---------------------------------------------------------------- write FSM: state register
    always_ff @(posedge clk156 or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            bad_q        <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            bad_q        <= bad_d;
            ovf_q        <= ovf_d;
        end
    end

    // ---------------------------------------------------------------- write FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StWrite: begin
                if (s_axis_tvalid) begin
                    if (s_axis_tlast) begin
                        state_d = StIdle;
                    end else begin
                        state_d = has_space ? StWrite : StDrop;
                    end
                end
            end
            StDrop: begin
                if (s_axis_tvalid && s_axis_tlast) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // ---------------------------------------------------------------- write FSM: outputs
    always_comb begin
        ram_we       = 1'b0;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        bad_d        = 1'b0;
        ovf_d        = 1'b0;
        if (state_q != StDrop && s_axis_tvalid) begin
            if (has_space) begin
                ram_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
                if (s_axis_tlast) begin
                    if (s_axis_tuser) begin
                        commit_ptr_d = wr_ptr_q + 1'b1;
                    end else begin
                        // Rewind only to the last commit, so committed data stays intact.
                        wr_ptr_d = commit_ptr_q;
                        bad_d    = 1'b1;
                    end
                end
            end else begin
                wr_ptr_d = commit_ptr_q;
                ovf_d    = 1'b1;
            end
        end
    end

    assign rx_bad_frame     = bad_q;
    assign rx_fifo_overflow = ovf_q;

    // ---------------------------------------------------------------- storage
    logic              rd_issue;
    logic [EntryW-1:0] ram_rdata;

    isolation_sdp_ram #(
        .WIDTH      (EntryW),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk_i   (clk156),
        .we_i    (ram_we),
        .waddr_i (wr_ptr_q[ADDR_WIDTH-1:0]),
        .wdata_i ({s_axis_tlast, s_axis_tkeep, s_axis_tdata}),
        .re_i    (rd_issue),
        .raddr_i (rd_ptr_q[ADDR_WIDTH-1:0]),
        .rdata_o (ram_rdata)
    );

    // ---------------------------------------------------------------- read side
    // Two stages: RAM read register (ram_vld_q) feeding the output register. A read is issued
    // whenever the RAM stage is empty or is being moved on this cycle, giving one beat/cycle.
    logic ram_vld_q, ram_vld_d;
    logic out_free, load_out;

    assign out_free = !m_axis_tvalid || m_axis_tready;
    assign load_out = ram_vld_q && out_free;
    assign rd_issue = (rd_ptr_q != commit_ptr_q) && (!ram_vld_q || load_out);
    assign rd_ptr_d = rd_ptr_q + PtrW'(rd_issue);

    always_comb begin
        ram_vld_d = ram_vld_q;
        if (rd_issue) begin
            ram_vld_d = 1'b1;
        end else if (load_out) begin
            ram_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk156 or posedge reset) begin
        if (reset) begin
            rd_ptr_q      <= '0;
            ram_vld_q     <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            ram_vld_q <= ram_vld_d;
            if (load_out) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= ram_rdata[DATA_WIDTH-1:0];
                m_axis_tkeep  <= ram_rdata[DATA_WIDTH +: KEEP_WIDTH];
                m_axis_tlast  <= ram_rdata[EntryW-1];
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

    // ---------------------------------------------------------------- statistics
`ifdef RX_PKT_ISOLATION_STATS_EN
    logic [StatsCntWidth-1:0] good_cnt_q, bad_cnt_q, ovf_cnt_q;
    logic                     good_evt;

    assign good_evt = commit_ptr_d != commit_ptr_q;

    always_ff @(posedge clk156 or posedge reset) begin
        if (reset) begin
            good_cnt_q <= '0;
            bad_cnt_q  <= '0;
            ovf_cnt_q  <= '0;
        end else begin
            if (good_evt && good_cnt_q != '1) good_cnt_q <= good_cnt_q + 1'b1;
            if (bad_d && bad_cnt_q != '1)     bad_cnt_q  <= bad_cnt_q + 1'b1;
            if (ovf_d && ovf_cnt_q != '1)     ovf_cnt_q  <= ovf_cnt_q + 1'b1;
        end
    end

    assign rx_good_count = good_cnt_q;
    assign rx_bad_count  = bad_cnt_q;
    assign rx_ovf_count  = ovf_cnt_q;
`else
    assign rx_good_count = '0;
    assign rx_bad_count  = '0;
    assign rx_ovf_count  = '0;
`endif

endmodule

// File: tb/tb_rx_packet_isolation.sv
// Self-checking bench for rx_packet_isolation (DATA_WIDTH=64, ADDR_WIDTH=4).
module tb_rx_packet_isolation;

    localparam int DW = 64;
    localparam int KW = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] s_tdata;
    logic [KW-1:0] s_tkeep;
    logic          s_tvalid, s_tlast, s_tuser;
    logic [DW-1:0] m_tdata;
    logic [KW-1:0] m_tkeep;
    logic          m_tvalid, m_tlast, m_tready;
    logic          ovf_pulse, bad_pulse;
    logic [31:0]   good_cnt, bad_cnt, ovf_cnt;

    always #5 clk = ~clk;

    rx_packet_isolation #(
        .DATA_WIDTH (DW),
        .KEEP_WIDTH (KW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk156           (clk),
        .reset            (rst),
        .s_axis_tdata     (s_tdata),
        .s_axis_tkeep     (s_tkeep),
        .s_axis_tvalid    (s_tvalid),
        .s_axis_tlast     (s_tlast),
        .s_axis_tuser     (s_tuser),
        .m_axis_tdata     (m_tdata),
        .m_axis_tkeep     (m_tkeep),
        .m_axis_tvalid    (m_tvalid),
        .m_axis_tlast     (m_tlast),
        .m_axis_tready    (m_tready),
        .rx_fifo_overflow (ovf_pulse),
        .rx_bad_frame     (bad_pulse),
        .rx_good_count    (good_cnt),
        .rx_bad_count     (bad_cnt),
        .rx_ovf_count     (ovf_cnt)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
    } beat_t;

    typedef struct {
        int beats;
        bit tuser;
        bit exp_out;
        int exp_bad;
        int exp_ovf;
    } vec_t;

    beat_t exp_q[$];
    vec_t  vecs[7];

    int checks = 0;
    int passed = 0;
    int bad_seen = 0;
    int ovf_seen = 0;
    int ovf_beat;
    int exp_good = 0, exp_bad = 0, exp_ovf = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    // Scoreboard / stability monitor, sampling on the falling edge.
    logic  prev_stall = 1'b0;
    logic [DW+KW+1:0] prev_out;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (bad_pulse) bad_seen++;
            if (ovf_pulse) ovf_seen++;
            if (prev_stall) check("stable_while_stalled", {m_tvalid, m_tlast, m_tkeep, m_tdata},
                                  prev_out);
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_beat: got data %0h, required no beat", m_tdata);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check("out_data", m_tdata, e.data);
                    check("out_keep", m_tkeep, e.keep);
                    check("out_last", m_tlast, e.last);
                end
            end
            prev_stall = m_tvalid && !m_tready;
            prev_out   = {m_tvalid, m_tlast, m_tkeep, m_tdata};
        end
    end

    task automatic drive_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l,
                              input logic u);
        s_tdata  = d;
        s_tkeep  = k;
        s_tlast  = l;
        s_tuser  = u;
        s_tvalid = 1'b1;
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tuser  = 1'b0;
    endtask

    // Sends one packet; beat data = {id, beat index}. Records the beat on which an
    // overflow pulse first appears.
    task automatic send_pkt(input int id, input int n, input bit good, input bit exp_out,
                            input int first);
        logic [KW-1:0] lk;
        logic [KW-1:0] ones;
        ones = '1;
        lk   = ones >> (id % KW);
        for (int b = 0; b < n; b++) begin
            logic [DW-1:0] d;
            logic [KW-1:0] k;
            logic          l;
            d = {32'(id), 32'(first + b)};
            l = (b == n - 1);
            k = l ? lk : ones;
            if (exp_out) exp_q.push_back('{data: d, keep: k, last: l});
            drive_beat(d, k, l, l ? good : 1'b0);
            if (ovf_pulse && ovf_beat < 0) ovf_beat = b + 1;
        end
        if (exp_out) exp_good++;
        else if (!good) exp_bad++;
        else exp_ovf++;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL %s_drain: got %0d beats outstanding, required 0", name, exp_q.size());
    endtask

    task automatic check_stats(input string name);
`ifdef RX_PKT_ISOLATION_STATS_EN
        check({name, "_good"}, good_cnt, 32'(exp_good));
        check({name, "_bad"},  bad_cnt,  32'(exp_bad));
        check({name, "_ovf"},  ovf_cnt,  32'(exp_ovf));
`else
        check({name, "_good_tied"}, good_cnt, 32'd0);
        check({name, "_bad_tied"},  bad_cnt,  32'd0);
        check({name, "_ovf_tied"},  ovf_cnt,  32'd0);
`endif
    endtask

    initial begin
        int b0, o0;
        // beats, tuser, delivered, bad pulses, overflow pulses
        vecs[0] = '{3,  1'b0, 1'b0, 1, 0};
        vecs[1] = '{2,  1'b1, 1'b1, 0, 0};
        vecs[2] = '{1,  1'b1, 1'b1, 0, 0};
        vecs[3] = '{1,  1'b0, 1'b0, 1, 0};
        vecs[4] = '{16, 1'b1, 1'b1, 0, 0};
        vecs[5] = '{5,  1'b1, 1'b1, 0, 0};
        vecs[6] = '{1,  1'b1, 1'b1, 0, 0};

        rst = 1'b1; s_tdata = '0; s_tkeep = '0; s_tvalid = 1'b0; s_tlast = 1'b0;
        s_tuser = 1'b0; m_tready = 1'b1;
        #2;
        check("rst_tvalid", m_tvalid, 1'b0);
        check("rst_tdata",  m_tdata,  64'd0);
        check("rst_tkeep",  m_tkeep,  8'd0);
        check("rst_tlast",  m_tlast,  1'b0);
        check("rst_ovf",    ovf_pulse, 1'b0);
        check("rst_bad",    bad_pulse, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_stats("rst_stats");

        // Latency: first beat valid exactly two edges after the last input beat.
        send_pkt(1, 4, 1'b1, 1'b1, 0);
        check("lat_edge_n",   m_tvalid, 1'b0);
        @(posedge clk); #1;
        check("lat_edge_n1",  m_tvalid, 1'b0);
        @(posedge clk); #1;
        check("lat_edge_n2",  m_tvalid, 1'b1);
        wait_drain("latency");

        // Table of packets with tready held high.
        for (int i = 0; i < 7; i++) begin
            b0 = bad_seen;
            o0 = ovf_seen;
            send_pkt(10 + i, vecs[i].beats, vecs[i].tuser, vecs[i].exp_out, 0);
            @(posedge clk); #1;
            check($sformatf("vec%0d_bad_pulses", i), 32'(bad_seen - b0), 32'(vecs[i].exp_bad));
            check($sformatf("vec%0d_ovf_pulses", i), 32'(ovf_seen - o0), 32'(vecs[i].exp_ovf));
        end
        wait_drain("table");

        // 20-beat packet against a stalled output: single overflow pulse at beat 17.
        m_tready = 1'b0;
        o0 = ovf_seen; ovf_beat = -1;
        send_pkt(30, 20, 1'b1, 1'b0, 0);
        repeat (4) @(posedge clk); #1;
        check("ovf20_pulses", 32'(ovf_seen - o0), 32'd1);
        check("ovf20_beat",   32'(ovf_beat), 32'd17);
        check("ovf20_no_out", m_tvalid, 1'b0);
        m_tready = 1'b1;
        send_pkt(31, 5, 1'b1, 1'b1, 0);
        wait_drain("after_ovf20");

        // Overflow on the last beat drops the good packet; FSM must be idle right after.
        m_tready = 1'b0;
        o0 = ovf_seen; ovf_beat = -1;
        send_pkt(32, 17, 1'b1, 1'b0, 0);
        send_pkt(33, 2, 1'b1, 1'b1, 0);
        check("ovf17_pulses", 32'(ovf_seen - o0), 32'd1);
        check("ovf17_beat",   32'(ovf_beat), 32'd17);
        m_tready = 1'b1;
        wait_drain("after_ovf17");

        // Exactly-full packet fits with a stalled reader.
        m_tready = 1'b0;
        o0 = ovf_seen;
        send_pkt(34, 16, 1'b1, 1'b1, 0);
        @(posedge clk); #1;
        check("fit16_no_ovf", 32'(ovf_seen - o0), 32'd0);
        m_tready = 1'b1;
        wait_drain("fit16");

        // 40 single-beat packets with tready toggling; input paced to the output rate.
        for (int i = 0; i < 40; i++) begin
            logic [DW-1:0] d;
            d = {32'(100 + i), 32'd0};
            exp_q.push_back('{data: d, keep: 8'hFF, last: 1'b1});
            m_tready = 1'b1;
            drive_beat(d, 8'hFF, 1'b1, 1'b1);
            m_tready = 1'b0;
            @(posedge clk); #1;
        end
        exp_good += 40;
        m_tready = 1'b1;
        wait_drain("singles40");
        check_stats("pre_reset_stats");

        // Reset in the middle of a 6-beat packet with a stalled beat in the output register.
        m_tready = 1'b0;
        send_pkt(200, 2, 1'b1, 1'b1, 0);
        repeat (3) @(posedge clk); #1;
        check("pre_reset_valid", m_tvalid, 1'b1);
        drive_beat({32'd201, 32'd0}, 8'hFF, 1'b0, 1'b0);
        drive_beat({32'd201, 32'd1}, 8'hFF, 1'b0, 1'b0);
        s_tdata = {32'd201, 32'd2}; s_tkeep = 8'hFF; s_tvalid = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("mid_reset_tvalid", m_tvalid, 1'b0);
        check("mid_reset_tdata",  m_tdata,  64'd0);
        check("mid_reset_tkeep",  m_tkeep,  8'd0);
        check("mid_reset_tlast",  m_tlast,  1'b0);
        s_tvalid = 1'b0;
        exp_q.delete();
        exp_good = 0; exp_bad = 0; exp_ovf = 0;
        repeat (2) @(posedge clk); #1;
        rst = 1'b0;
        m_tready = 1'b1;
        send_pkt(201, 3, 1'b1, 1'b1, 3);
        send_pkt(202, 2, 1'b1, 1'b1, 0);
        wait_drain("post_reset");
        check_stats("post_reset_stats");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
